// File: rtl/booth_r4_step.sv
// Radix-4 Booth multiplier iteration engine: retires two multiplier bits per cycle and
// feeds the pre-shift accumulator word to the shift stage. Optional macro: BOOTH_UNSIGNED_EN.
module booth_r4_step #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_start,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 i_signed,
`endif
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product,
  output logic [2*WIDTH:0]     o_data
);

  localparam int AW   = WIDTH + 2;
  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [AW-1:0]     a_q, a_d, m_q, m_d;
  logic [WIDTH-1:0]         q_q, q_d;
  logic                     qm1_q, qm1_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic [2*WIDTH-1:0]       prod_q, prod_d;
  logic                     sgn_q;

  logic [2:0]               rec;
  logic                     ext_step, last_step;
  logic signed [AW-1:0]     addend, sum;
  logic [AW+WIDTH:0]        shifted;

`ifdef BOOTH_UNSIGNED_EN
  logic sgn_d;
`else
  assign sgn_q = 1'b1;
`endif

  // Unsigned runs need one extra digit (the multiplier's zero extension), added without a shift.
  assign ext_step  = !sgn_q && (cnt_q == CW'(HALF));
  assign last_step = sgn_q ? (cnt_q == CW'(HALF - 1)) : (cnt_q == CW'(HALF));
  assign rec       = ext_step ? {2'b00, qm1_q} : {q_q[1:0], qm1_q};

  always_comb begin
    case (rec)
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = m_q <<< 1;
      3'b100:         addend = -(m_q <<< 1);
      3'b101, 3'b110: addend = -m_q;
      default:        addend = '0;
    endcase
  end

  assign sum     = a_q + addend;
  assign shifted = {{2{sum[AW-1]}}, sum, q_q[WIDTH-1:1]};
  assign o_data  = (state_q == RUN) ? {sum[WIDTH-1:0], q_q, qm1_q} : '0;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
`ifdef BOOTH_UNSIGNED_EN
    sgn_d   = sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          a_d     = '0;
          q_d     = i_mplier;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef BOOTH_UNSIGNED_EN
          sgn_d   = i_signed;
          m_d     = i_signed ? {{2{i_mcand[WIDTH-1]}}, i_mcand} : {2'b00, i_mcand};
`else
          m_d     = {{2{i_mcand[WIDTH-1]}}, i_mcand};
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (ext_step) begin
          a_d = sum;
        end else begin
          {a_d, q_d, qm1_d} = shifted;
        end
        if (last_step) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          prod_d  = {a_d[WIDTH-1:0], q_d};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

`ifdef BOOTH_UNSIGNED_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sgn_q <= 1'b0;
    else        sgn_q <= sgn_d;
  end
`endif

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_product = prod_q;

endmodule

// File: tb/tb_booth_r4_step.sv
// Self-checking bench for booth_r4_step: vector table, random operands against an
// arithmetic model, and hand-written start-ignore / reset-abort sequences.
module tb_booth_r4_step;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           n_rst;
  logic           i_start;
  logic [W-1:0]   i_mcand, i_mplier;
`ifdef BOOTH_UNSIGNED_EN
  logic           i_signed;
`endif
  logic           o_busy, o_done;
  logic [2*W-1:0] o_product;
  logic [2*W:0]   o_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_r4_step #(.WIDTH(W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_start   (i_start),
`ifdef BOOTH_UNSIGNED_EN
    .i_signed  (i_signed),
`endif
    .i_mcand   (i_mcand),
    .i_mplier  (i_mplier),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_product (o_product),
    .o_data    (o_data)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Pre-shift word at step k: the partial product M * (signed value of mplier[2k+1:0]) has its
  // low W+2k bits on top, the not-yet-retired multiplier bits below, then the last retired bit.
  function automatic logic [64:0] data_model(input logic [31:0] m, input logic [31:0] q, input int k);
    logic signed [127:0] mx, p, x;
    logic [127:0] r;
    mx = {{96{m[31]}}, m};
    p  = '0;
    for (int i = 0; i < 128; i++) p[i] = (i <= 2*k+1) ? q[i] : q[2*k+1];
    x = mx * p;
    r = (x << (33 - 2*k)) | (({96'b0, q} >> (2*k)) << 1);
    if (k > 0) r[0] = q[2*k-1];
    return r[64:0];
  endfunction

  // Starts at a negedge and ends at a negedge one cycle after o_done, with the FSM back in IDLE.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp_p, input int inject_at, input bit inject_done,
                        input bit check_data);
    int iters;
    iters = sgn ? W/2 : W/2 + 1;
    i_start = 1'b1; i_mcand = a; i_mplier = b;
`ifdef BOOTH_UNSIGNED_EN
    i_signed = sgn;
`endif
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < iters; k++) begin
      chk({name, "_busy"}, o_busy, 1'b1);
      chk({name, "_done_early"}, o_done, 1'b0);
      if (check_data) chk($sformatf("%s_data%0d", name, k), o_data, data_model(a, b, k));
      if (k == inject_at) begin
        i_start = 1'b1; i_mcand = 32'd9; i_mplier = 32'd9;
      end
      @(negedge clk);
      i_start = 1'b0;
    end
    chk({name, "_done"}, o_done, 1'b1);
    chk({name, "_busy_off"}, o_busy, 1'b0);
    chk({name, "_product"}, o_product, exp_p);
    chk({name, "_data_idle"}, o_data, 65'd0);
    if (inject_done) begin
      i_start = 1'b1; i_mcand = 32'd9; i_mplier = 32'd9;
    end
    @(negedge clk);
    i_start = 1'b0;
    chk({name, "_done_pulse"}, o_done, 1'b0);
    chk({name, "_idle"}, o_busy, 1'b0);
    chk({name, "_hold"}, o_product, exp_p);
    $display("op %s mcand=%h mplier=%h signed=%0d product=%h", name, a, b, sgn, o_product);
  endtask

  initial begin
    logic [31:0]        ra, rb;
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub;

    vecs[0] = '{32'd3,         32'd5,         64'd15};
    vecs[1] = '{32'hFFFF_FFF9, 32'd6,         64'hFFFF_FFFF_FFFF_FFD6};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[5] = '{32'h1234_5678, 32'd0,         64'd0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};

    n_rst = 1'b0; i_start = 1'b0; i_mcand = '0; i_mplier = '0;
`ifdef BOOTH_UNSIGNED_EN
    i_signed = 1'b1;
`endif
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_product", o_product, 64'd0);
    chk("rst_data", o_data, 65'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Back-to-back: each op starts on the first IDLE cycle after the previous one.
    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b1, vecs[i].p, -1, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 5 == 0) rb[31] = 1'b1;
      sa = {{32{ra[31]}}, ra};
      sb = {{32{rb[31]}}, rb};
      run_op($sformatf("rnd%0d", i), ra, rb, 1'b1, sa * sb, -1, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Start requests during RUN and during DONE are both dropped.
    run_op("ignore", 32'd3, 32'd5, 1'b1, 64'd15, 5, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("ignore_no_done", o_done, 1'b0);
      chk("ignore_no_busy", o_busy, 1'b0);
      @(negedge clk);
    end
    run_op("nine", 32'd9, 32'd9, 1'b1, 64'd81, -1, 1'b0, 1'b1);

    // Reset in the middle of a run aborts it with no completion pulse.
    i_start = 1'b1; i_mcand = 32'd100; i_mplier = 32'd7;
    @(negedge clk);
    i_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_busy_pre", o_busy, 1'b1);
    n_rst = 1'b0;
    #1;
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_done", o_done, 1'b0);
    chk("abort_product", o_product, 64'd0);
    chk("abort_data", o_data, 65'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_hold_done", o_done, 1'b0);
    end
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", o_done, 1'b0);
      chk("abort_no_busy", o_busy, 1'b0);
    end
    run_op("two", 32'd2, 32'd2, 1'b1, 64'd4, -1, 1'b0, 1'b1);

`ifdef BOOTH_UNSIGNED_EN
    run_op("uns_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, -1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      ua = {32'b0, ra};
      ub = {32'b0, rb};
      run_op($sformatf("uns%0d", i), ra, rb, 1'b0, ua * ub, -1, 1'b0, 1'b0);
    end
    run_op("sgn_mode", 32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, -1, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_r4_step.md
# booth_r4_step

Radix-4 (modified) Booth iteration engine for the multiplier datapath, sitting directly upstream of the `shift_right` PIPO register stage. It accepts a signed multiplicand/multiplier pair on a start pulse and recodes the multiplier two bits per cycle. Each cycle it adds 0, ±M or ±2M into the upper half of the accumulator and drives the pre-shift accumulator word toward the shift stage. It applies the 2-bit arithmetic shift, signals completion and holds the 2W-bit product.

## Interface
- `WIDTH`, 32, operand width in bits; must be even and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `n_rst`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  load operands and begin; sampled only in IDLE.
- `i_mcand`  in  WIDTH  multiplicand M, two's complement.
- `i_mplier`  in  WIDTH  multiplier Q, two's complement.
- `o_busy`  out  1  high in RUN.
- `o_done`  out  1  one-cycle pulse when the product is valid.
- `o_product`  out  2*WIDTH  signed product, held until next accepted start.
- `o_data`  out  2*WIDTH+1  pre-shift word {A[WIDTH-1:0], Q, q_m1} for the shift stage, valid when `o_busy`.

## Operation
- Internal state: A (WIDTH+2 bits, signed), Q (WIDTH), q_m1 (1), M (WIDTH+2, sign-extended), iteration counter (clog2(WIDTH/2)+1 bits).
- FSM states and transitions:
  - IDLE → RUN on `i_start`. Load A=0, Q=`i_mplier`, q_m1=0, M=sext(`i_mcand`), count=0.
  - RUN → DONE when count == WIDTH/2-1 and that step completes.
  - DONE → IDLE unconditionally after one cycle.
- Recoding of {Q[1],Q[0],q_m1}:
  - 000 and 111: +0.
  - 001 and 010: +M.
  - 011: +2M.
  - 100: −2M.
  - 101 and 110: −M.
- Negation is the two's complement in WIDTH+2 bits.
- Each RUN cycle: S = A + addend, computed in WIDTH+2 bits with wrap and no saturation. Then {A,Q,q_m1} ← arithmetic right shift by 2 of {S,Q,q_m1}, with the sign of S replicated into the top two bits.
- `o_data` = {S[WIDTH-1:0], Q, q_m1} combinationally during RUN, and 0 otherwise.
- On entry to DONE: `o_product` ← {A[WIDTH-1:0], Q}. Exact for all signed inputs, including −2^(W−1) × −2^(W−1).
- `i_start` during RUN or DONE is ignored, and operand inputs are not re-sampled.
- `i_start` in the same cycle as the DONE→IDLE return is ignored. Start is accepted only when the FSM is in IDLE.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_product`=0, `o_data`=0, FSM=IDLE, all internal registers 0.
- `i_start` is sampled at edge 0. `o_busy` is high from edge 0 through edge WIDTH/2.
- `o_done` is high for exactly one cycle after edge WIDTH/2, which gives a latency of WIDTH/2+1 cycles (17 for WIDTH=32).
- `o_product` updates at the same edge that raises `o_done` and is stable thereafter.
- Back-to-back operation: the earliest next accepted start is 2 cycles after `o_done` rises, i.e. one cycle in IDLE.
- Reset asserted mid-RUN: all outputs go to reset values immediately, with no `o_done`. Operation resumes only on a new `i_start` after reset is released.

## Configuration
- `BOOTH_UNSIGNED_EN` defined:
  - Adds input port `i_signed` (1 bit), sampled with `i_start`.
  - When `i_signed`=0, M and Q are zero-extended to WIDTH+2 bits. The run takes WIDTH/2+1 iterations, and the final product is {A,Q} truncated to 2*WIDTH bits, unsigned.
  - When `i_signed`=1, behaviour is the same as without the macro.
- `BOOTH_UNSIGNED_EN` undefined: no `i_signed` port; always signed; always WIDTH/2 iterations.

## Test plan
- WIDTH=32; `i_mcand`=3, `i_mplier`=5, pulse start → `o_done` 17 cycles later and `o_product`=64'd15; `o_busy` high for 16 cycles.
- `i_mcand`=−7, `i_mplier`=6 → `o_product`=64'hFFFF_FFFF_FFFF_FFD6; `i_mcand`=−1, `i_mplier`=−1 → 64'd1.
- `i_mcand`=`i_mplier`=32'h8000_0000 → `o_product`=64'h4000_0000_0000_0000. This checks the ±2M headroom.
- Start 3×5, then at cycle 5 drive `i_start` with 9×9 → the 9×9 request is ignored, `o_product`=15, and no second `o_done`. Then start 9×9 in IDLE → 81.
- Deassert `n_rst` at cycle 8 of a run → all outputs 0 asynchronously, no `o_done`. Release reset and start 2×2 → 4.
- With `BOOTH_UNSIGNED_EN`: `i_signed`=0, operands 32'hFFFF_FFFF × 32'hFFFF_FFFF → `o_product`=64'hFFFF_FFFE_0000_0001 after 18 cycles.
